fp_add_cmp_conv_unit: RTL and testbench
=======================================

Name: fp_add_cmp_conv_unit

Overview:
- Single-precision IEEE-754 arithmetic unit for the Phaethon ALU.
- Provides four operations: add, subtract, signed-int-to-float conversion and ordered compare.
- ALU presents operands plus a one-cycle enable; the unit registers its result one clock later.
- Feeds the FaddRR / FsubRR / FconvR / FminRR / FmaxRR execution path.

Parameters:
- WIDTH, 32, operand/result width (only 32 supported).
- QNAN, 32'h7FC00000, canonical NaN emitted for invalid results.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  start strobe; operands/op sampled on a rising clk edge while high
- op  input  2  00 add, 01 sub (a-b), 10 convert a (signed int32) to float, 11 compare
- a  input  32  operand A (float, or int32 for op 10)
- b  input  32  operand B (ignored for op 10)
- result  output  32  float result (add/sub/convert); held otherwise
- cmp  output  2  compare result: 00 a==b, 01 a>b, 11 a<b, 10 unordered
- valid  output  1  one-cycle pulse, result/cmp updated
- debug  output  32  {22'b0, op_last[1:0], exp_pre_pack[7:0]}

Behaviour:
- Reset (reset low, async): result=0, cmp=00, valid=0, debug=0.
- Latency: exactly 1 clock.
  - enable high at edge N → result/cmp/debug loaded and valid=1 after edge N.
  - valid=0 after edge N+1 unless enable is high again.
- Throughput is 1 per clock; back-to-back enables are allowed.
- enable low: all outputs hold, valid=0.
- Add/sub only write result; compare only writes cmp; convert only writes result. The untouched output holds its prior value.
- Datapath is combinational from a/b/op into the output registers. No multicycle path.
- Add/sub:
  - Negate b's sign for sub.
  - Align the smaller-exponent mantissa (hidden bit restored) with guard/sticky, add or subtract, normalise via leading-zero count.
  - Rounding is toward zero (truncate); no round-to-nearest.
  - Denormal inputs are flushed to ±0; denormal results are flushed to +0.
  - Exact zero result from x-x is +0.
  - Exponent overflow → ±Inf (0x7F800000 / 0xFF800000).
  - NaN input or Inf-Inf → QNAN.
  - Inf+finite → that Inf; Inf+Inf same sign → Inf.
- Convert:
  - a is signed two's complement.
  - 0 → 0x00000000.
  - Magnitude normalised; bits beyond 24 significant bits are truncated.
  - 0x80000000 → 0xCF000000.
- Compare:
  - Total order on finite and Inf values.
  - +0 equals -0; denormals are flushed before comparison.
  - Any NaN operand → 10.
- Reset asserted mid-operation: the pending result is discarded and outputs return to reset values immediately.
- debug updates on every accepted enable.

Decomposition:
- Shared package fp_pkg holds:
  - op encodings FP_ADD, FP_SUB, FP_CONV, FP_CMP.
  - cmp encodings CMP_EQ, CMP_GT, CMP_LT, CMP_UN.
  - field constants: EXP_BIAS=127, EXP_MAX=255, QNAN, PINF, NINF.
- One sub-module, fp_lzc32: 32-bit leading-zero counter, shared by add normalisation and int conversion.

Test Plan:
- Reset low then high, no enable → result=0, cmp=00, valid=0; reset low mid-run clears valid within the same cycle.
- op=00, a=0x3F800000, b=0x40000000 → one cycle later result=0x40400000, valid=1 for one cycle.
- op=01, a=b=0x3F800000 → result=0x00000000. op=01, a=0x3F800000, b=0x40000000 → 0xBF800000.
- op=10:
  - a=5 → 0x40A00000
  - a=0xFFFFFFFF → 0xBF800000
  - a=16777217 → 0x4B800000
  - a=0x80000000 → 0xCF000000
- op=11:
  - (0x3F800000, 0x40000000) → cmp=11
  - reversed → 01
  - (0x00000000, 0x80000000) → 00
  - (0x7FC00000, 0x3F800000) → 10
- Specials:
  - op=00 with 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
  - 0x7F800000 + 0xFF800000 → 0x7FC00000.
  - Back-to-back enables on 3 consecutive cycles → 3 consecutive valid pulses with matching results.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared encodings and IEEE-754 single-precision field constants for the FP add/compare/convert unit.
package fp_pkg;

    typedef enum logic [1:0] {
        FP_ADD  = 2'b00,
        FP_SUB  = 2'b01,
        FP_CONV = 2'b10,
        FP_CMP  = 2'b11
    } fpOp_t;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_GT = 2'b01,
        CMP_UN = 2'b10,
        CMP_LT = 2'b11
    } fpCmp_t;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;

    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] PINF = 32'h7F800000;
    localparam logic [31:0] NINF = 32'hFF800000;

endpackage

// File: rtl/fp_lzc32.sv
// 32-bit leading-zero counter; an all-zero input reports 32.
module fp_lzc32 (
    input  logic [31:0] value,
    output logic [5:0]  count
);

    // Scanning upward lets the highest set bit win without an early exit.
    always_comb begin
        count = 6'd32;
        for (int unsigned i = 0; i < 32; i++) begin
            if (value[i]) begin
                count = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/fp_add_cmp_conv_unit.sv
// Single-precision add/sub, int32-to-float convert and ordered compare; one-cycle registered result.
module fp_add_cmp_conv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter logic [31:0] QNAN  = fp_pkg::QNAN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       cmp,
    output logic             valid,
    output logic [31:0]      debug
);
    import fp_pkg::*;

    fpOp_t opSel;
    assign opSel = fpOp_t'(op);

    logic [7:0]  expA, expB;
    logic        nanA, nanB, infA, infB;
    logic [30:0] magA, magB;
    logic        signA, signB, signBEff;

    assign expA     = a[30:23];
    assign expB     = b[30:23];
    assign nanA     = (expA == 8'hFF) && (a[22:0] != '0);
    assign nanB     = (expB == 8'hFF) && (b[22:0] != '0);
    assign infA     = (expA == 8'hFF) && (a[22:0] == '0);
    assign infB     = (expB == 8'hFF) && (b[22:0] == '0);
    assign magA     = (expA == '0) ? '0 : a[30:0];
    assign magB     = (expB == '0) ? '0 : b[30:0];
    assign signA    = a[31];
    assign signB    = b[31];
    assign signBEff = signB ^ (opSel == FP_SUB);

    logic        bigSign, effSub;
    logic [7:0]  bigExp, smallExp, expDiff;
    logic [23:0] bigMant, smallMant;
    logic [4:0]  shAmt;
    logic [53:0] alignExt;
    logic [26:0] bigAl, smallAl;
    logic [27:0] sum;

    // Lowest aligned bit carries only sticky, so truncation after a one-bit left shift stays exact.
    always_comb begin
        if (magA >= magB) begin
            bigSign   = signA;
            bigExp    = magA[30:23];
            smallExp  = magB[30:23];
            bigMant   = {magA[30:23] != '0, magA[22:0]};
            smallMant = {magB[30:23] != '0, magB[22:0]};
        end else begin
            bigSign   = signBEff;
            bigExp    = magB[30:23];
            smallExp  = magA[30:23];
            bigMant   = {magB[30:23] != '0, magB[22:0]};
            smallMant = {magA[30:23] != '0, magA[22:0]};
        end
        effSub   = signA ^ signBEff;
        expDiff  = bigExp - smallExp;
        shAmt    = (expDiff > 8'd27) ? 5'd27 : expDiff[4:0];
        alignExt = {smallMant, 30'b0} >> shAmt;
        smallAl  = {alignExt[53:28], |alignExt[27:0]};
        bigAl    = {bigMant, 3'b000};
        sum      = effSub ? ({1'b0, bigAl} - {1'b0, smallAl})
                          : ({1'b0, bigAl} + {1'b0, smallAl});
    end

    logic [31:0] convMag, lzcIn, normd;
    logic [5:0]  lz;

    assign convMag = a[31] ? (~a + 32'd1) : a;
    assign lzcIn   = (opSel == FP_CONV) ? convMag : {sum, 4'b0000};

    fp_lzc32 lzcInst (
        .value (lzcIn),
        .count (lz)
    );

    assign normd = lzcIn << lz;

    logic [9:0]  addExp;
    logic [7:0]  convExp;
    logic [31:0] addRes, convRes;

    assign addExp  = {2'b00, bigExp} + 10'd1 - {4'b0000, lz};
    assign convExp = 8'd158 - {2'b00, lz};
    assign convRes = (a == '0) ? '0 : {a[31], convExp, normd[30:8]};

    always_comb begin
        addRes = '0;
        if (nanA || nanB) begin
            addRes = QNAN;
        end else if (infA && infB) begin
            addRes = (signA == signBEff) ? (signA ? NINF : PINF) : QNAN;
        end else if (infA) begin
            addRes = signA ? NINF : PINF;
        end else if (infB) begin
            addRes = signBEff ? NINF : PINF;
        end else if (sum == '0 || addExp[9] || addExp == '0) begin
            addRes = '0;
        end else if (addExp >= 10'(EXP_MAX)) begin
            addRes = bigSign ? NINF : PINF;
        end else begin
            addRes = {bigSign, addExp[7:0], normd[30:8]};
        end
    end

    logic [1:0] cmpRes;
    logic       cmpSignA, cmpSignB;

    // Flushed zeros compare as positive so +0 and -0 are equal.
    assign cmpSignA = (magA != '0) && signA;
    assign cmpSignB = (magB != '0) && signB;

    always_comb begin
        cmpRes = CMP_EQ;
        if (nanA || nanB) begin
            cmpRes = CMP_UN;
        end else if (cmpSignA != cmpSignB) begin
            cmpRes = cmpSignA ? CMP_LT : CMP_GT;
        end else if (magA != magB) begin
            cmpRes = ((magA > magB) ^ cmpSignA) ? CMP_GT : CMP_LT;
        end
    end

    logic [7:0] expPrePack;

    always_comb begin
        case (opSel)
            FP_ADD, FP_SUB: expPrePack = addExp[7:0];
            FP_CONV:        expPrePack = convExp;
            default:        expPrePack = '0;
        endcase
    end

    logic unusedBits;
    assign unusedBits = ^{normd[31], normd[7:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result <= '0;
            cmp    <= CMP_EQ;
            valid  <= 1'b0;
            debug  <= '0;
        end else begin
            valid <= enable;
            if (enable) begin
                debug <= {22'b0, op, expPrePack};
                case (opSel)
                    FP_ADD, FP_SUB: result <= addRes;
                    FP_CONV:        result <= convRes;
                    default:        cmp    <= cmpRes;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fp_add_cmp_conv_unit.sv
// Directed-vector bench for fp_add_cmp_conv_unit: table of single ops plus reset and back-to-back sequences.
module tb_fp_add_cmp_conv_unit;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [31:0] result;
    logic [1:0]  cmp;
    logic        valid;
    logic [31:0] debug;

    int errors = 0;
    int checks = 0;

    fp_add_cmp_conv_unit #(
        .WIDTH (32),
        .QNAN  (32'h7FC00000)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .cmp    (cmp),
        .valid  (valid),
        .debug  (debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expRes;
        logic [1:0]  expCmp;
        logic        chkDbg;
        logic [31:0] expDbg;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    task automatic setVec(input int i, input string name, input logic [1:0] o,
                          input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] r, input logic [1:0] c,
                          input logic cd, input logic [31:0] d);
        vecs[i].name   = name;
        vecs[i].op     = o;
        vecs[i].a      = va;
        vecs[i].b      = vb;
        vecs[i].expRes = r;
        vecs[i].expCmp = c;
        vecs[i].chkDbg = cd;
        vecs[i].expDbg = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Expected result/cmp include held values carried from the previous vector.
        setVec(0,  "add_1p2",      2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b00, 1'b1, 32'h00000080);
        setVec(1,  "sub_1m1",      2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000, 2'b00, 1'b0, 32'h0);
        setVec(2,  "sub_1m2",      2'b01, 32'h3F800000, 32'h40000000, 32'hBF800000, 2'b00, 1'b0, 32'h0);
        setVec(3,  "conv_5",       2'b10, 32'h00000005, 32'h00000000, 32'h40A00000, 2'b00, 1'b1, 32'h00000281);
        setVec(4,  "conv_m1",      2'b10, 32'hFFFFFFFF, 32'h00000000, 32'hBF800000, 2'b00, 1'b0, 32'h0);
        setVec(5,  "conv_2p24p1",  2'b10, 32'h01000001, 32'h00000000, 32'h4B800000, 2'b00, 1'b0, 32'h0);
        setVec(6,  "conv_intmin",  2'b10, 32'h80000000, 32'h00000000, 32'hCF000000, 2'b00, 1'b0, 32'h0);
        setVec(7,  "cmp_lt",       2'b11, 32'h3F800000, 32'h40000000, 32'hCF000000, 2'b11, 1'b1, 32'h00000300);
        setVec(8,  "cmp_gt",       2'b11, 32'h40000000, 32'h3F800000, 32'hCF000000, 2'b01, 1'b0, 32'h0);
        setVec(9,  "cmp_pz_nz",    2'b11, 32'h00000000, 32'h80000000, 32'hCF000000, 2'b00, 1'b0, 32'h0);
        setVec(10, "cmp_nan",      2'b11, 32'h7FC00000, 32'h3F800000, 32'hCF000000, 2'b10, 1'b0, 32'h0);
        setVec(11, "add_ovf",      2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 2'b10, 1'b0, 32'h0);
        setVec(12, "add_inf_ninf", 2'b00, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 2'b10, 1'b0, 32'h0);
        setVec(13, "add_inf_1",    2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000, 2'b10, 1'b0, 32'h0);
        setVec(14, "sub_trunc24",  2'b01, 32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 2'b10, 1'b0, 32'h0);
        setVec(15, "sub_sticky",   2'b01, 32'h3F800000, 32'h30800000, 32'h3F7FFFFF, 2'b10, 1'b0, 32'h0);
        setVec(16, "add_denorm",   2'b00, 32'h3F800000, 32'h00400000, 32'h3F800000, 2'b10, 1'b0, 32'h0);
        setVec(17, "cmp_denorm",   2'b11, 32'h00000001, 32'h80000000, 32'h3F800000, 2'b00, 1'b0, 32'h0);
        setVec(18, "cmp_neg",      2'b11, 32'hBF800000, 32'hC0000000, 32'h3F800000, 2'b01, 1'b0, 32'h0);
        setVec(19, "conv_0",       2'b10, 32'h00000000, 32'h00000000, 32'h00000000, 2'b01, 1'b0, 32'h0);

        reset  = 1'b0;
        enable = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        check("rst_result", result, 32'h0);
        check("rst_cmp",    {30'b0, cmp}, 32'h0);
        check("rst_valid",  {31'b0, valid}, 32'h0);
        check("rst_debug",  debug, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_valid",  {31'b0, valid}, 32'h0);
        check("idle_result", result, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            enable = 1'b1;
            op     = vecs[i].op;
            a      = vecs[i].a;
            b      = vecs[i].b;
            @(posedge clk); #1;
            check({vecs[i].name, "_valid"},  {31'b0, valid}, 32'h1);
            check({vecs[i].name, "_result"}, result, vecs[i].expRes);
            check({vecs[i].name, "_cmp"},    {30'b0, cmp}, {30'b0, vecs[i].expCmp});
            check({vecs[i].name, "_dbgop"},  {8'b0, debug[31:8]}, {30'b0, vecs[i].op});
            if (vecs[i].chkDbg) check({vecs[i].name, "_debug"}, debug, vecs[i].expDbg);
            @(negedge clk);
            enable = 1'b0;
            a      = 32'h12345678;
            @(posedge clk); #1;
            check({vecs[i].name, "_vdrop"}, {31'b0, valid}, 32'h0);
            check({vecs[i].name, "_hold"},  result, vecs[i].expRes);
        end

        // Back-to-back enables on three consecutive edges.
        @(negedge clk);
        enable = 1'b1; op = 2'b00; a = 32'h3F800000; b = 32'h40000000;
        @(posedge clk); #1;
        check("b2b0_valid",  {31'b0, valid}, 32'h1);
        check("b2b0_result", result, 32'h40400000);
        @(negedge clk);
        op = 2'b10; a = 32'h00000005; b = 32'h0;
        @(posedge clk); #1;
        check("b2b1_valid",  {31'b0, valid}, 32'h1);
        check("b2b1_result", result, 32'h40A00000);
        @(negedge clk);
        op = 2'b01; a = 32'h3F800000; b = 32'h40000000;
        @(posedge clk); #1;
        check("b2b2_valid",  {31'b0, valid}, 32'h1);
        check("b2b2_result", result, 32'hBF800000);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        check("b2b_end_valid", {31'b0, valid}, 32'h0);

        // Reset asserted mid-cycle clears outputs without waiting for a clock edge.
        @(negedge clk);
        enable = 1'b1; op = 2'b11; a = 32'h7FC00000; b = 32'h0;
        @(posedge clk); #1;
        check("mid_pre_valid", {31'b0, valid}, 32'h1);
        check("mid_pre_cmp",   {30'b0, cmp}, 32'h2);
        #1 reset = 1'b0;
        #1;
        check("mid_valid",  {31'b0, valid}, 32'h0);
        check("mid_result", result, 32'h0);
        check("mid_cmp",    {30'b0, cmp}, 32'h0);
        check("mid_debug",  debug, 32'h0);
        @(negedge clk);
        enable = 1'b0;
        reset  = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", {31'b0, valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
